// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI note scheduler: status nibbles,
// parser states, the decoded note message and a one-hot index helper.
package midi_pkg;

  localparam logic [3:0] ST_NOTE_OFF  = 4'h8;
  localparam logic [3:0] ST_NOTE_ON   = 4'h9;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  typedef enum logic [1:0] {
    P_IDLE    = 2'd0,
    P_WAIT_D1 = 2'd1,
    P_WAIT_D2 = 2'd2,
    P_IGNORE  = 2'd3
  } parse_st_e;

  typedef struct packed {
    logic       is_on;
    logic [6:0] note;
    logic [6:0] vel;
  } midi_msg_t;

  // Index of the set bit of a one-hot (or zero) vector; zero maps to 0.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (v[i]) idx = idx | 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser for Note On/Off with running status; emits a
// registered one-cycle message strobe and a parse-error pulse.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'h0,
  parameter bit         OMNI    = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_byte_i,
  output logic       msg_vld_o,
  output midi_msg_t  msg_o,
  output logic       parse_err_o
);

  parse_st_e  st_q;
  logic       rs_on_q;
  logic [6:0] note_q;
  logic       msg_vld_q;
  midi_msg_t  msg_q;
  logic       perr_q;

  logic is_status, is_rt, ch_ok, is_note_st;

  assign is_status  = rx_byte_i[7];
  assign is_rt      = rx_byte_i >= REALTIME_MIN;
  assign ch_ok      = OMNI || (rx_byte_i[3:0] == CHANNEL);
  assign is_note_st = (rx_byte_i[7:4] == ST_NOTE_OFF) || (rx_byte_i[7:4] == ST_NOTE_ON);

  // Running status lives in the state: WAIT_D1/WAIT_D2 imply a valid note
  // status, IGNORE means it was cleared by a foreign status byte.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      st_q      <= P_IDLE;
      rs_on_q   <= 1'b0;
      note_q    <= 7'd0;
      msg_vld_q <= 1'b0;
      msg_q     <= '0;
      perr_q    <= 1'b0;
    end else begin
      msg_vld_q <= 1'b0;
      perr_q    <= 1'b0;
      if (rx_valid_i && !is_rt) begin
        if (is_status) begin
          if (is_note_st && ch_ok) begin
            rs_on_q <= rx_byte_i[4];
            st_q    <= P_WAIT_D1;
          end else begin
            st_q    <= P_IGNORE;
          end
        end else begin
          case (st_q)
            P_IDLE:    perr_q <= 1'b1;
            P_WAIT_D1: begin
              note_q <= rx_byte_i[6:0];
              st_q   <= P_WAIT_D2;
            end
            P_WAIT_D2: begin
              msg_q     <= '{is_on: rs_on_q && (rx_byte_i[6:0] != 7'd0),
                             note:  note_q,
                             vel:   rx_byte_i[6:0]};
              msg_vld_q <= 1'b1;
              st_q      <= P_WAIT_D1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign msg_vld_o   = msg_vld_q;
  assign msg_o       = msg_q;
  assign parse_err_o = perr_q;

endmodule

// File: rtl/midi_voice_sched.sv
// Polyphonic voice allocator: retrigger on matching note, else lowest free
// voice, else round-robin steal. Owns the per-voice gate/note/vel registers.
module midi_voice_sched
  import midi_pkg::*;
#(
  parameter int         NUM_VOICES = 4,
  parameter logic [3:0] CHANNEL    = 4'h0,
  parameter bit         OMNI       = 1'b0
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    RX_VALID,
  input  logic [7:0]              RX_BYTE,
  output logic [NUM_VOICES-1:0]   VOICE_GATE,
  output logic [8*NUM_VOICES-1:0] VOICE_NOTE,
  output logic [8*NUM_VOICES-1:0] VOICE_VEL,
  output logic                    EVT_VALID,
  output logic [2:0]              EVT_VOICE,
  output logic                    EVT_STEAL,
  output logic                    PARSE_ERR
);

  localparam int NV = NUM_VOICES;
  localparam logic [NV-1:0] ONE = {{(NV-1){1'b0}}, 1'b1};

  logic      msg_vld;
  midi_msg_t msg;

  midi_msg_parser #(.CHANNEL(CHANNEL), .OMNI(OMNI)) u_parser (
    .CLK         (CLK),
    .RESET       (RESET),
    .rx_valid_i  (RX_VALID),
    .rx_byte_i   (RX_BYTE),
    .msg_vld_o   (msg_vld),
    .msg_o       (msg),
    .parse_err_o (PARSE_ERR)
  );

  logic [NV-1:0]      gate_q;
  logic [NV-1:0][6:0] note_q;
  logic [NV-1:0][6:0] vel_q;
  logic [2:0]         steal_q;
  logic               evt_valid_q, evt_steal_q;
  logic [2:0]         evt_voice_q;

  logic [NV-1:0] match, free, hit_oh, free_oh, steal_oh;
  logic [NV-1:0] ld_d, vel_d, clr_d, evt_d;
  logic          steal_d;

  for (genvar gi = 0; gi < NV; gi++) begin : g_lane
    assign match[gi] = gate_q[gi] && (note_q[gi] == msg.note);
    assign free[gi]  = !gate_q[gi];
    assign VOICE_NOTE[8*gi +: 8] = {1'b0, note_q[gi]};
    assign VOICE_VEL[8*gi +: 8]  = {1'b0, vel_q[gi]};
  end

  // Lowest set bit isolates the priority winner of each request vector.
  assign hit_oh   = match & (~match + ONE);
  assign free_oh  = free & (~free + ONE);
  assign steal_oh = ONE << steal_q;

  always_comb begin
    ld_d    = '0;
    vel_d   = '0;
    clr_d   = '0;
    steal_d = 1'b0;
    if (msg_vld) begin
      if (msg.is_on) begin
        if (|match)     vel_d = hit_oh;
        else if (|free) ld_d  = free_oh;
        else begin
          ld_d    = steal_oh;
          steal_d = 1'b1;
        end
      end else begin
        clr_d = hit_oh;
      end
    end
    evt_d = ld_d | vel_d | clr_d;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      gate_q      <= '0;
      note_q      <= '0;
      vel_q       <= '0;
      steal_q     <= 3'd0;
      evt_valid_q <= 1'b0;
      evt_voice_q <= 3'd0;
      evt_steal_q <= 1'b0;
    end else begin
      for (int i = 0; i < NV; i++) begin
        if (ld_d[i]) begin
          gate_q[i] <= 1'b1;
          note_q[i] <= msg.note;
          vel_q[i]  <= msg.vel;
        end
        if (vel_d[i]) vel_q[i]  <= msg.vel;
        if (clr_d[i]) gate_q[i] <= 1'b0;
      end
      evt_valid_q <= |evt_d;
      evt_voice_q <= onehot_to_idx(8'(evt_d));
      evt_steal_q <= steal_d;
      if (steal_d)
        steal_q <= (steal_q == 3'(NV-1)) ? 3'd0 : steal_q + 3'd1;
    end
  end

  assign VOICE_GATE = gate_q;
  assign EVT_VALID  = evt_valid_q;
  assign EVT_VOICE  = evt_voice_q;
  assign EVT_STEAL  = evt_steal_q;

endmodule
